frame_capture_ctrl: RTL
=======================

// Module: frame_capture_ctrl
// PURPOSE
//  Write-side controller for the camera frame buffer BRAM (port A), in the pixel-clock domain.
//  Takes 12-bit processed pixels plus valid and frame-done strobes from the camera path.
//  Sequences BRAM writes so every capture starts on a frame boundary.
//  Supports continuous capture or a single snapshot requested from the clk_65mhz domain by a toggle handshake.
// PARAMETERS
//  ADDR_W        17     BRAM port-A address width
//  PIX_W         12     pixel / BRAM data width
//  FRAME_PIXELS  76800  pixels per frame (320x240); must be <= 2**ADDR_W
// PORTS
//  pclk_in             in   1       pixel clock; all logic on posedge
//  reset               in   1       synchronous, active-high
//  mode_cont_in        in   1       1 = continuous capture, 0 = snapshot mode (quasi-static)
//  snap_req_tgl_in     in   1       toggle from clk_65mhz domain; each edge = one snapshot request
//  pixel_valid_in      in   1       pixel_in valid this cycle
//  pixel_in            in   PIX_W   processed pixel
//  frame_done_in       in   1       1-cycle strobe at end of camera frame
//  bram_addr_out       out  ADDR_W  BRAM port-A address
//  bram_din_out        out  PIX_W   BRAM port-A write data
//  bram_we_out         out  1       BRAM port-A write enable
//  busy_out            out  1       state != IDLE
//  snap_done_tgl_out   out  1       toggles once per completed snapshot (back to clk_65mhz domain)
//  frames_out          out  8       completed captured frames, wraps 255->0
//  short_frame_out     out  1       sticky: a captured frame ended with fewer than FRAME_PIXELS pixels
//  overflow_out        out  1       sticky: pixels arrived after FRAME_PIXELS within one frame
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, write pointer 0, sync flops 0.
//    Reset mid-capture aborts and drops any pending request; no done toggle is issued.
//  - snap_req_tgl_in passes through a 2-flop synchronizer plus an edge register.
//    A request is detected 3 pclk cycles after the toggle.
//  - States:
//    - IDLE: go to ARMED if mode_cont_in=1, or if mode_cont_in=0 and a request is detected.
//    - ARMED: clear short/overflow flags; ptr<=0; on frame_done_in go to CAPTURE (the partial frame is discarded).
//    - CAPTURE: write pixels; on frame_done_in close the frame:
//      - frames_out += 1.
//      - If ptr_after_this_cycle != FRAME_PIXELS, set short_frame_out.
//      - If mode_cont_in=1: stay in CAPTURE, ptr<=0.
//      - Else: toggle snap_done_tgl_out, go to IDLE.
//  - Write path is registered, 1-cycle latency:
//    - In CAPTURE, pixel_valid_in && ptr < FRAME_PIXELS gives, next cycle:
//      bram_we_out=1, bram_addr_out=ptr, bram_din_out=pixel_in.
//    - ptr increments on each such write.
//    - bram_we_out=0 in all other cycles; addr/din hold their last values.
//  - pixel_valid_in with ptr == FRAME_PIXELS: no write, set overflow_out, ptr holds.
//  - pixel_valid_in and frame_done_in in the same cycle: the pixel is written as the last pixel of the closing frame, then ptr<=0.
//  - Snapshot requests during ARMED, CAPTURE or CLEAR, or while mode_cont_in=1, are ignored (not queued).
//  - mode_cont_in change mid-frame takes effect only at the next frame_done_in or IDLE decision.
//  - Continuous to snapshot: the current frame completes, snap_done toggles, then IDLE.
// CONFIGURATION
//  - Macro FRAME_CLEAR_EN defined: adds state CLEAR between IDLE and ARMED.
//    - Writes 0 to addresses 0..FRAME_PIXELS-1, one per cycle (we=1), then goes to ARMED.
//    - Camera pixels are ignored during CLEAR; frame_done_in is ignored.
//    - busy_out=1 throughout.
//  - Macro FRAME_CLEAR_EN undefined: IDLE goes directly to ARMED; no CLEAR logic is synthesized.
// TESTING (bench uses FRAME_PIXELS=16, ADDR_W=5)
//  1. Snapshot: toggle req; send a partial frame, frame_done, 16 valid pixels 0x100..0x10F, frame_done.
//     -> No writes before the first frame_done; 16 writes to addr 0..15 with matching data.
//     -> frames_out=1, snap_done toggles once, busy_out=0 afterwards, short=0, overflow=0.
//  2. Continuous: mode_cont_in=1; run 3 frames of 16 pixels.
//     -> Each frame writes addr 0..15; frames_out=3; snap_done never toggles.
//  3. Boundaries: frame of 10 pixels -> short_frame_out=1.
//     Next capture: 20 pixels -> only addr 0..15 written, overflow_out=1.
//     Re-arm -> both flags clear.
//  4. Simultaneous: 16th pixel valid in the same cycle as frame_done -> written to addr 15, short_frame_out=0.
//     The next frame starts at addr 0.
//  5. Reset mid-CAPTURE after 5 writes -> next cycle outputs 0, state IDLE, snap_done not toggled.
//     A new request restarts capture from addr 0.
//  6. FRAME_CLEAR_EN: snapshot request -> 16 consecutive writes of 0 to addr 0..15, then ARMED.
//     Pixels during CLEAR are not written.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
//   Write-side controller for the camera frame buffer BRAM (port A). It runs
//   entirely in the pixel-clock domain. Each capture starts on a frame
//   boundary. Two capture modes are supported:
//   - continuous capture;
//   - single snapshot, requested from the clk_65mhz domain by a toggle
//     handshake.
//
//   Optional build macro FRAME_CLEAR_EN: adds a CLEAR state between IDLE and
//   ARMED. CLEAR zero-fills the whole frame buffer before capture is armed.
//
// Ports
//   pclk_in            pixel clock, all logic on posedge
//   reset              synchronous, active-high
//   mode_cont_in       1 = continuous capture, 0 = snapshot (quasi-static)
//   snap_req_tgl_in    snapshot request toggle from clk_65mhz domain
//   pixel_valid_in     pixel_in valid this cycle
//   pixel_in           processed pixel
//   frame_done_in      1-cycle strobe at end of camera frame
//   bram_addr_out      BRAM port-A address
//   bram_din_out       BRAM port-A write data
//   bram_we_out        BRAM port-A write enable
//   busy_out           controller not idle
//   snap_done_tgl_out  toggles once per completed snapshot
//   frames_out         completed captured frames (wraps)
//   short_frame_out    sticky: a captured frame had too few pixels
//   overflow_out       sticky: pixels arrived past the end of a frame
//
// States
//   state    | meaning
//   IDLE     | waiting for continuous mode or a snapshot request
//   CLEAR    | zero-filling the buffer (FRAME_CLEAR_EN builds only)
//   ARMED    | discarding the partial frame in flight, waiting for frame_done
//   CAPTURE  | writing pixels of the current frame

module frame_capture_ctrl #(
  parameter int ADDR_W       = 17,
  parameter int PIX_W        = 12,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic              pclk_in,
  input  logic              reset,
  input  logic              mode_cont_in,
  input  logic              snap_req_tgl_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              frame_done_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [PIX_W-1:0]  bram_din_out,
  output logic              bram_we_out,
  output logic              busy_out,
  output logic              snap_done_tgl_out,
  output logic [7:0]        frames_out,
  output logic              short_frame_out,
  output logic              overflow_out
);

  // One extra bit so the pointer can hold FRAME_PIXELS itself when the frame
  // size equals the full address space.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FP_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef FRAME_CLEAR_EN
  localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRAME_PIXELS - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
`ifdef FRAME_CLEAR_EN
    ST_CAPTURE = 2'd2,
    ST_CLEAR   = 2'd3
`else
    ST_CAPTURE = 2'd2
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  ptr, ptr_nxt, ptr_after;
  logic              pix_ok;
  logic              we_nxt;
  logic [PIX_W-1:0]  din_nxt;
  logic              frame_close, short_set, ovf_set, flags_clr, done_tgl;
  logic              req_s1, req_s2, req_s3, req_det;

  // Two synchronizer flops, then an edge register; any level change is a request.
  assign req_det  = req_s2 ^ req_s3;
  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge pclk_in) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    we_nxt      = 1'b0;
    din_nxt     = pixel_in;
    frame_close = 1'b0;
    short_set   = 1'b0;
    ovf_set     = 1'b0;
    flags_clr   = 1'b0;
    done_tgl    = 1'b0;
    pix_ok      = pixel_valid_in && (ptr < FP_CNT);
    ptr_after   = pix_ok ? ptr + CNT_ONE : ptr;

    case (state)
      ST_IDLE: begin
        ptr_nxt = '0;
        if (mode_cont_in || req_det) begin
`ifdef FRAME_CLEAR_EN
          state_nxt = ST_CLEAR;
`else
          state_nxt = ST_ARMED;
`endif
        end
      end
`ifdef FRAME_CLEAR_EN
      ST_CLEAR: begin
        we_nxt  = 1'b1;
        din_nxt = '0;
        ptr_nxt = ptr + CNT_ONE;
        if (ptr == FP_LAST) state_nxt = ST_ARMED;
      end
`endif
      ST_ARMED: begin
        flags_clr = 1'b1;
        ptr_nxt   = '0;
        if (frame_done_in) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        we_nxt  = pix_ok;
        ptr_nxt = ptr_after;
        if (pixel_valid_in && !pix_ok) ovf_set = 1'b1;
        // A pixel arriving with frame_done belongs to the closing frame, so
        // the short check uses the pointer including this cycle's write.
        if (frame_done_in) begin
          frame_close = 1'b1;
          ptr_nxt     = '0;
          if (ptr_after != FP_CNT) short_set = 1'b1;
          if (!mode_cont_in) begin
            done_tgl  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_in) begin
    if (reset) begin
      ptr               <= '0;
      bram_we_out       <= 1'b0;
      bram_addr_out     <= '0;
      bram_din_out      <= '0;
      frames_out        <= '0;
      short_frame_out   <= 1'b0;
      overflow_out      <= 1'b0;
      snap_done_tgl_out <= 1'b0;
      req_s1            <= 1'b0;
      req_s2            <= 1'b0;
      req_s3            <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      bram_we_out <= we_nxt;
      if (we_nxt) begin
        bram_addr_out <= ptr[ADDR_W-1:0];
        bram_din_out  <= din_nxt;
      end
      if (frame_close) frames_out <= frames_out + 8'd1;
      if (flags_clr) begin
        short_frame_out <= 1'b0;
        overflow_out    <= 1'b0;
      end else begin
        if (short_set) short_frame_out <= 1'b1;
        if (ovf_set)   overflow_out    <= 1'b1;
      end
      if (done_tgl) snap_done_tgl_out <= ~snap_done_tgl_out;
      req_s1 <= snap_req_tgl_in;
      req_s2 <= req_s1;
      req_s3 <= req_s2;
    end
  end

endmodule
